instr_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register, PC+4 adder and PC source mux with a registered fetch PC, an instruction-memory request stream with a fixed 1-cycle read latency, and a prefetch queue. Downstream decode sees a valid/ready stream of {pc, pc_plus_step, instruction}. Branch and jump resolution from execute arrives as a redirect that flushes all stale fetches.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// The fetch queue stores entries as {pc, instr}; the helper below gives the packed width.
package fetch_pkg;

  localparam int          DEFAULT_PC_STEP  = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with flush and occupancy count.
// The head is read straight from the array so a pushed entry is visible the next cycle, never the same one.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = pop && !empty;
  assign w_push    = push && (!w_full || w_pop);
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && w_full && !pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: registered fetch PC, 1-cycle imem requests gated by queue credit,
// prefetch queue toward decode, and redirect handling that flushes stale fetches.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter int                    PC_STEP    = DEFAULT_PC_STEP
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_rdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          inst_valid,
  input  logic                          inst_ready,
  output logic [DATA_WIDTH-1:0]         inst_data,
  output logic [ADDR_WIDTH-1:0]         inst_pc,
  output logic [ADDR_WIDTH-1:0]         inst_pc_next,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                    CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int                    EW        = entry_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_V    = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] STEP_MASK = ~ADDR_WIDTH'(PC_STEP - 1);

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_inflight;
  logic                  r_kill;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_req;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [CW:0]           w_credit;
  logic [EW-1:0]         w_head;

  // Slots committed after this edge: queued + in flight - leaving now.
  // Counting the pop lets a full queue keep streaming at one entry per cycle.
  assign w_pop    = inst_valid && inst_ready;
  assign w_credit = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
  assign w_req    = !rst && !redirect_valid && (w_credit < (CW + 1)'(FIFO_DEPTH));
  assign w_push   = r_inflight && !r_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_req;
      r_kill     <= redirect_valid && r_inflight;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & STEP_MASK;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + STEP_V;
      end
      if (w_req) begin
        r_req_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data ({r_req_pc, imem_rdata}),
    .pop       (w_pop),
    .head_data (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign imem_req               = w_req;
  assign imem_addr              = r_fetch_pc;
  assign inst_valid             = !w_empty && !redirect_valid;
  assign {inst_pc, inst_data}   = w_head;
  assign inst_pc_next           = inst_pc + STEP_V;
  assign fifo_count             = w_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed vector table, hand-written reset/backpressure/wrap
// sequences, then randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc, inst_pc_next;
  logic [2:0]  fifo_count;

  logic        redirect_valid_w = 1'b0;
  logic [31:0] redirect_pc_w = '0;
  logic        inst_ready_w = 1'b1;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w = '0;
  logic        inst_valid_w;
  logic [31:0] inst_data_w, inst_pc_w, inst_pc_next_w;
  logic [2:0]  fifo_count_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: data = addr ^ KEY one cycle after the request, junk otherwise.
  always @(posedge clk) imem_rdata   <= imem_req   ? (imem_addr   ^ KEY) : $urandom;
  always @(posedge clk) imem_rdata_w <= imem_req_w ? (imem_addr_w ^ KEY) : $urandom;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_pc_next(inst_pc_next), .fifo_count(fifo_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w), .inst_valid(inst_valid_w),
    .inst_ready(inst_ready_w), .inst_data(inst_data_w), .inst_pc(inst_pc_w),
    .inst_pc_next(inst_pc_next_w), .fifo_count(fifo_count_w)
  );

  typedef struct {
    bit          rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    int          e_count;
    bit          e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit rv, logic [31:0] rpc, bit rdy,
                              bit ev, logic [31:0] epc, int ec, bit er, logic [31:0] ea);
    vec_t v;
    v.rst = r; v.redir = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_count = ec; v.e_req = er; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input bit ev, input logic [31:0] epc,
                             input int ec, input bit er, input logic [31:0] ea);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(ev));
    chk({tag, ".count"}, 32'(fifo_count), 32'(ec));
    chk({tag, ".req"},   32'(imem_req),   32'(er));
    if (er) chk({tag, ".addr"}, imem_addr, ea);
    if (ev) begin
      chk({tag, ".pc"},      inst_pc,      epc);
      chk({tag, ".data"},    inst_data,    epc ^ KEY);
      chk({tag, ".pc_next"}, inst_pc_next, epc + 32'd4);
    end
  endtask

  task automatic chk_wrap(input string tag, input logic [31:0] epc);
    chk({tag, ".valid"},   32'(inst_valid_w), 32'd1);
    chk({tag, ".pc"},      inst_pc_w,         epc);
    chk({tag, ".data"},    inst_data_w,       epc ^ KEY);
    chk({tag, ".pc_next"}, inst_pc_next_w,    epc + 32'd4);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    @(negedge clk);
  endtask

  // Reference model state: entries the decode side should see, next fetch address, pending response.
  int unsigned q[$];
  int unsigned m_fetch;
  int unsigned m_infl_pc;
  int          m_infl;

  initial begin
    int n;

    // Streaming, backpressure, redirect over a full queue, redirect on arriving response,
    // back-to-back redirects. Fields: rst redir rpc rdy | valid pc count req addr.
    vecs.push_back(mk(1,0,0,1,     0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h0));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h4));
    vecs.push_back(mk(0,0,0,1,     1,32'h0,1,1,32'h8));
    vecs.push_back(mk(0,0,0,1,     1,32'h4,1,1,32'hC));
    vecs.push_back(mk(0,0,0,1,     1,32'h8,1,1,32'h10));
    vecs.push_back(mk(0,0,0,0,     1,32'hC,1,1,32'h14));
    vecs.push_back(mk(0,0,0,0,     1,32'hC,2,1,32'h18));
    vecs.push_back(mk(0,0,0,0,     1,32'hC,3,0,32'h1C));
    vecs.push_back(mk(0,0,0,0,     1,32'hC,4,0,32'h1C));
    vecs.push_back(mk(0,0,0,0,     1,32'hC,4,0,32'h1C));
    vecs.push_back(mk(0,0,0,1,     1,32'hC,4,1,32'h1C));
    vecs.push_back(mk(0,0,0,1,     1,32'h10,3,1,32'h20));
    vecs.push_back(mk(0,1,32'h43,1, 0,0,3,0,32'h24));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h40));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h44));
    vecs.push_back(mk(0,0,0,1,     1,32'h40,1,1,32'h48));
    vecs.push_back(mk(0,0,0,1,     1,32'h44,1,1,32'h4C));
    vecs.push_back(mk(0,1,32'h100,1,0,0,1,0,32'h50));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h100));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h104));
    vecs.push_back(mk(0,0,0,1,     1,32'h100,1,1,32'h108));
    vecs.push_back(mk(0,1,32'h200,1,0,0,1,0,32'h10C));
    vecs.push_back(mk(0,1,32'h304,1,0,0,0,0,32'h200));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h304));
    vecs.push_back(mk(0,0,0,1,     0,0,0,1,32'h308));
    vecs.push_back(mk(0,0,0,1,     1,32'h304,1,1,32'h30C));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      $display("vec %0d: valid=%0b pc=%h count=%0d req=%0b addr=%h",
               i, inst_valid, inst_pc, fifo_count, imem_req, imem_addr);
      chk_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                  vecs[i].e_count, vecs[i].e_req, vecs[i].e_addr);
    end

    // Backpressure from reset: exactly four requests, then in-order drain and resume at 0x10.
    drive(1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (imem_req) begin
        chk("bp.req_addr", imem_addr, 32'(n * 4));
        n++;
      end
    end
    chk("bp.req_total", 32'(n), 32'd4);
    chk("bp.count", 32'(fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      $display("bp drain %0d: pc=%h", i, inst_pc);
      chk_outputs($sformatf("bp.drain%0d", i), 1, 32'(i * 4), (i == 0) ? 4 : 3, 1, 32'h10 + 32'(i * 4));
    end

    // Reset with three queued entries and one response in flight; also releases the wrap instance.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    chk("rst.pre_count", 32'(fifo_count), 32'd3);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk_outputs("rst.c1", 0, 0, 0, 1, 32'h0);
    drive(0, 0, 0, 1);
    chk_outputs("rst.c2", 0, 0, 0, 1, 32'h4);
    drive(0, 0, 0, 1);
    chk_outputs("rst.c3", 1, 32'h0, 1, 1, 32'h8);
    chk_wrap("wrap.0", 32'hFFFF_FFF8);
    drive(0, 0, 0, 1);
    chk_wrap("wrap.1", 32'hFFFF_FFFC);
    drive(0, 0, 0, 1);
    chk_wrap("wrap.2", 32'h0000_0000);
    $display("wrap sequence: last pc=%h", inst_pc_w);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0);
    q.delete();
    m_fetch = 0;
    m_infl = 0;
    m_infl_pc = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit          r, rv, rdy, ev, pop, er;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rv  = !r && ($urandom_range(0, 99) < 6);
      rpc = $urandom;
      rdy = ($urandom_range(0, 99) < 70);
      drive(r, rv, rpc, rdy);
      ev  = (q.size() > 0) && !rv;
      pop = ev && rdy;
      er  = !r && !rv && ((int'(q.size()) + m_infl - int'(pop)) < 4);
      if (r) begin
        chk("rand.req_in_rst", 32'(imem_req), 32'd0);
      end else begin
        chk_outputs("rand", ev, ev ? q[0] : 32'h0, q.size(), er, m_fetch);
      end
      if (pop && !r) $display("rand pop: pc=%h data=%h", inst_pc, inst_data);
      if (r) begin
        q.delete(); m_fetch = 0; m_infl = 0;
      end else if (rv) begin
        q.delete(); m_fetch = rpc & ~32'h3; m_infl = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (m_infl != 0) q.push_back(m_infl_pc);
        if (er) begin
          m_infl = 1; m_infl_pc = m_fetch; m_fetch = m_fetch + 4;
        end else begin
          m_infl = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
